// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage of the nRISC 8-bit core.
// Holds the PC, fetches one byte per req/ack handshake and presents the latched
// instruction (plus its opcode/campo_a/campo_b slices) to decode. Supports stall,
// branch redirect with squash of an in-flight fetch, and an optional halt opcode.
// Optional feature macro: BUSCA_HALT_EN (opcode 4'hF halts the unit until reset).
module unidade_busca #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] pc_out,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_dado,
    input  logic       stall,
    input  logic       desvio,
    input  logic [7:0] desvio_alvo,
    output logic       instr_valida,
    output logic [7:0] instrucao,
    output logic [3:0] opcode,
    output logic [1:0] campo_a,
    output logic [1:0] campo_b,
    output logic [7:0] pc_instr,
    output logic       parado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
`ifdef BUSCA_HALT_EN
        ENTREGA = 2'd2,
        PARADO  = 2'd3
`else
        ENTREGA = 2'd2
`endif
    } estado_t;

    estado_t    r_estado;
    estado_t    w_prox_estado;
    logic [7:0] r_pc;
    logic [7:0] r_instrucao;
    logic [7:0] r_pc_instr;
    logic       r_descarte;   // an outstanding ack belongs to a squashed fetch
    logic [7:0] r_alvo_pend;  // redirect target to use once that ack arrives

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Next-state logic; an ack only completes a fetch if it is not being squashed.
    always_comb begin
        w_prox_estado = r_estado;
        unique case (r_estado)
            OCIOSO: w_prox_estado = BUSCA;
            BUSCA: begin
                if (mem_ack && !desvio && !r_descarte) begin
                    w_prox_estado = ENTREGA;
                end
            end
            ENTREGA: begin
                if (desvio) begin
                    w_prox_estado = BUSCA;
                end else if (!stall) begin
`ifdef BUSCA_HALT_EN
                    if (r_instrucao[7:4] == 4'hF) begin
                        w_prox_estado = PARADO;
                    end else begin
                        w_prox_estado = BUSCA;
                    end
`else
                    w_prox_estado = BUSCA;
`endif
                end
            end
`ifdef BUSCA_HALT_EN
            PARADO: w_prox_estado = PARADO;
`endif
            default: w_prox_estado = OCIOSO;
        endcase
    end

    // Outputs decoded from the registered state only, so no input reaches mem_req.
    always_comb begin
        mem_req      = 1'b0;
        instr_valida = 1'b0;
        parado       = 1'b0;
        unique case (r_estado)
            BUSCA:   mem_req      = 1'b1;
            ENTREGA: instr_valida = 1'b1;
`ifdef BUSCA_HALT_EN
            PARADO:  parado       = 1'b1;
`endif
            default: begin
                mem_req      = 1'b0;
                instr_valida = 1'b0;
            end
        endcase
    end

    // Datapath: PC, latched instruction and squash bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_instrucao <= 8'h00;
            r_pc_instr  <= 8'h00;
            r_descarte  <= 1'b0;
            r_alvo_pend <= 8'h00;
        end else begin
            unique case (r_estado)
                BUSCA: begin
                    if (mem_ack) begin
                        if (desvio) begin
                            r_pc       <= desvio_alvo;
                            r_descarte <= 1'b0;
                        end else if (r_descarte) begin
                            r_pc       <= r_alvo_pend;
                            r_descarte <= 1'b0;
                        end else begin
                            r_instrucao <= mem_dado;
                            r_pc_instr  <= r_pc;
                            r_pc        <= r_pc + 8'd1;
                        end
                    end else if (desvio) begin
                        // pc_out must stay frozen until the pending ack drains
                        r_descarte  <= 1'b1;
                        r_alvo_pend <= desvio_alvo;
                    end
                end
                ENTREGA: begin
                    if (desvio) begin
                        r_pc <= desvio_alvo;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    assign pc_out    = r_pc;
    assign instrucao = r_instrucao;
    assign pc_instr  = r_pc_instr;
    assign opcode    = r_instrucao[7:4];
    assign campo_a   = r_instrucao[3:2];
    assign campo_b   = r_instrucao[1:0];

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch stage of the nRISC 8-bit core. It holds the program counter and fetches one 8-bit instruction at a time from instruction memory over a req/ack handshake. It presents the latched instruction and its decoded fields to the decode stage, including the 2-bit `campo_b` that drives the 2-to-8 zero extender. It supports downstream stall, branch redirect with squash of in-flight fetches, and an optional halt opcode.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded at reset.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_out`  out  8  instruction memory address.
- `mem_req`  out  1  fetch request; `pc_out` must be stable while it is high.
- `mem_ack`  in  1  memory has `mem_dado` valid this cycle; ignored unless `mem_req` = 1.
- `mem_dado`  in  8  instruction byte.
- `stall`  in  1  decode cannot accept; hold the current instruction.
- `desvio`  in  1  branch taken; redirect to `desvio_alvo`.
- `desvio_alvo`  in  8  branch target address.
- `instr_valida`  out  1  `instrucao` and its fields are valid.
- `instrucao`  out  8  latched instruction.
- `opcode`  out  4  `instrucao[7:4]`.
- `campo_a`  out  2  `instrucao[3:2]`.
- `campo_b`  out  2  `instrucao[1:0]`, the register or 2-bit immediate fed to the extender.
- `pc_instr`  out  8  address the presented instruction was fetched from.
- `parado`  out  1  halted. Tied to 0 unless `BUSCA_HALT_EN` is defined.

## Operation
- FSM states: OCIOSO, BUSCA, ENTREGA, and PARADO (PARADO only with `BUSCA_HALT_EN`).
- Reset values:
  - state = OCIOSO, `pc_out` = `RESET_PC`, `mem_req` = 0, `instr_valida` = 0.
  - `instrucao` = 0, `pc_instr` = 0, `parado` = 0.
  - Internal `descarte` = 0, `alvo_pend` = 0.
- OCIOSO: next edge goes to BUSCA with `mem_req` = 1.
- BUSCA (`mem_req` = 1, `pc_out` frozen):
  - `desvio` without `mem_ack`: set `descarte` = 1, `alvo_pend` <= `desvio_alvo` (a later `desvio` overwrites it); stay in BUSCA.
  - `mem_ack` with `desvio` in the same cycle: drop the data, `pc_out` <= `desvio_alvo`, clear `descarte`, stay in BUSCA.
  - `mem_ack` with `descarte` = 1: drop the data, `pc_out` <= `alvo_pend`, clear `descarte`, stay in BUSCA.
  - `mem_ack` normal: `instrucao` <= `mem_dado`, `pc_instr` <= `pc_out`, `pc_out` <= `pc_out` + 1 (mod 256, so 8'hFF wraps to 8'h00), `instr_valida` <= 1, `mem_req` <= 0, go to ENTREGA.
- ENTREGA (`instr_valida` = 1, `mem_req` = 0):
  - `desvio` has priority over `stall`: `instr_valida` <= 0, `pc_out` <= `desvio_alvo`, go to BUSCA.
  - `stall` without `desvio`: hold all outputs unchanged.
  - Neither: instruction is consumed; `instr_valida` <= 0, go to BUSCA.
- `opcode`, `campo_a` and `campo_b` are combinational slices of `instrucao`.
- Asserting `reset` in any state, including mid-handshake, forces the reset values immediately. A late `mem_ack` after reset release is ignored, because in OCIOSO `mem_req` = 0.

## Timing
- Minimum fetch latency: `mem_req` rises 1 cycle after reset release. An ack in the first BUSCA cycle gives `instr_valida` on the next edge.
- No stall and zero-wait memory: one instruction every 2 cycles (BUSCA, ENTREGA).
- Redirect: the first request to the target is issued on the edge after `desvio` is seen in ENTREGA. In BUSCA it is issued on the edge after the outstanding ack.
- No combinational path from any input to `mem_req` or `pc_out`.

## Configuration
- `BUSCA_HALT_EN`:
  - Defined: when an instruction with `opcode` = 4'hF is consumed in ENTREGA (neither `stall` nor `desvio`), the unit goes to PARADO and `parado` <= 1. PARADO sets `mem_req` = 0 and `instr_valida` = 0, and stays until reset; `desvio` is ignored there.
  - Not defined: opcode 4'hF is fetched like any other instruction, there is no PARADO state, and `parado` is constant 0.

## Test plan
- Reset release, memory acks every request, data = address XOR 8'hA5: `instrucao` sequence is 8'hA5, 8'hA4, 8'hA7; `pc_instr` is 0, 1, 2; `instr_valida` pulses every 2nd cycle.
- `stall` held 3 cycles in ENTREGA with `instrucao` = 8'h6D: outputs are constant with `opcode` = 4'h6, `campo_a` = 2'b11, `campo_b` = 2'b01; `mem_req` stays 0.
- `desvio` to 8'h40 while BUSCA waits 2 cycles for ack: acked data is dropped, the next request has `pc_out` = 8'h40, and `pc_instr` of the first valid instruction = 8'h40.
- `desvio` and `stall` together in ENTREGA: `instr_valida` falls next edge and `pc_out` = target.
- PC at 8'hFF, normal fetch: next `pc_out` = 8'h00.
- `BUSCA_HALT_EN` defined, memory returns 8'hF0 at address 3: after consumption `parado` = 1, with no further `mem_req` for 20 cycles. Macro undefined: fetch continues at address 4.
